// File: rtl/spike_readout_classifier.sv
// Per-channel spike counting over a programmable window, followed by a sequential
// one-channel-per-cycle argmax scan that publishes class, winning count and margin.
module spike_readout_classifier #(
  parameter int NUM_CH = 10,
  parameter int CNT_W  = 8,
  parameter int WIN_W  = 16,
  parameter int IDX_W  = 4
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_i,
  input  logic              clear_i,
  input  logic              mode_i,
  input  logic [WIN_W-1:0]  window_len_i,
  input  logic [NUM_CH-1:0] spike_i,
  output logic              busy_o,
  output logic              valid_o,
  output logic [IDX_W-1:0]  class_o,
  output logic [CNT_W-1:0]  max_o,
  output logic [CNT_W-1:0]  margin_o,
  output logic              no_spike_o
);

  typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_SCAN, S_DONE} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CH - 1);

  state_t             r_state;
  state_t             w_state_next;

  logic [CNT_W-1:0]   r_cnt      [NUM_CH];
  logic [CNT_W-1:0]   w_cnt_next [NUM_CH];
  logic               w_cnt_zero;
  logic               w_accum;

  logic               r_mode;
  logic [WIN_W-1:0]   r_win_len;
  logic [WIN_W-1:0]   r_win_cnt;
  logic [WIN_W-1:0]   w_len_eff;
  logic               w_start_ok;

  logic [IDX_W-1:0]   r_scan_idx;
  logic [CNT_W-1:0]   w_scan_cnt;
  logic [CNT_W-1:0]   r_best;
  logic [CNT_W-1:0]   r_second;
  logic [IDX_W-1:0]   r_best_idx;

  logic               r_valid;
  logic [IDX_W-1:0]   r_class;
  logic [CNT_W-1:0]   r_max;
  logic [CNT_W-1:0]   r_margin;
  logic               r_no_spike;

  assign w_accum    = (r_state == S_ACCUM);
  assign w_start_ok = (r_state == S_IDLE) && start_i && !clear_i;
  assign w_len_eff  = (window_len_i == '0) ? WIN_W'(1) : window_len_i;
  // Counters restart on abort, on a new window, and between continuous windows.
  assign w_cnt_zero = clear_i || w_start_ok || ((r_state == S_DONE) && r_mode);
  assign w_scan_cnt = r_cnt[r_scan_idx];

  // FSM state register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_state <= S_IDLE;
    else         r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (start_i)                   w_state_next = S_ACCUM;
      S_ACCUM: if (r_win_cnt == WIN_W'(1))    w_state_next = S_SCAN;
      S_SCAN:  if (r_scan_idx == LAST_IDX)    w_state_next = S_DONE;
      S_DONE:  w_state_next = r_mode ? S_ACCUM : S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
    if (clear_i) w_state_next = S_IDLE;
  end

  // Saturating per-channel spike counters
  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_cnt
      assign w_cnt_next[gi] = w_cnt_zero ? '0 :
                              (w_accum && spike_i[gi] && (r_cnt[gi] != CNT_MAX)) ?
                              r_cnt[gi] + 1'b1 : r_cnt[gi];
    end
  endgenerate

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int k = 0; k < NUM_CH; k++) r_cnt[k] <= '0;
    end else begin
      for (int k = 0; k < NUM_CH; k++) r_cnt[k] <= w_cnt_next[k];
    end
  end

  // Window control; the length latched at start is reused by every continuous window.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_mode    <= 1'b0;
      r_win_len <= '0;
      r_win_cnt <= '0;
    end else if (w_start_ok) begin
      r_mode    <= mode_i;
      r_win_len <= w_len_eff;
      r_win_cnt <= w_len_eff;
    end else if (r_state == S_ACCUM) begin
      r_win_cnt <= r_win_cnt - 1'b1;
    end else if (r_state == S_DONE) begin
      r_win_cnt <= r_win_len;
    end
  end

  // Argmax scan: strict compare keeps the lowest index on ties.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_scan_idx <= '0;
      r_best     <= '0;
      r_second   <= '0;
      r_best_idx <= '0;
    end else if (r_state == S_ACCUM) begin
      r_scan_idx <= '0;
      r_best     <= '0;
      r_second   <= '0;
      r_best_idx <= '0;
    end else if (r_state == S_SCAN) begin
      if (w_scan_cnt > r_best) begin
        r_second   <= r_best;
        r_best     <= w_scan_cnt;
        r_best_idx <= r_scan_idx;
      end else if (w_scan_cnt > r_second) begin
        r_second <= w_scan_cnt;
      end
      r_scan_idx <= r_scan_idx + 1'b1;
    end
  end

  // Result registers hold between pulses and survive an abort.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_valid    <= 1'b0;
      r_class    <= '0;
      r_max      <= '0;
      r_margin   <= '0;
      r_no_spike <= 1'b0;
    end else if (clear_i) begin
      r_valid <= 1'b0;
    end else if (r_state == S_DONE) begin
      r_valid    <= 1'b1;
      r_class    <= r_best_idx;
      r_max      <= r_best;
      r_margin   <= r_best - r_second;
      r_no_spike <= (r_best == '0);
    end else begin
      r_valid <= 1'b0;
    end
  end

  assign busy_o     = (r_state != S_IDLE);
  assign valid_o    = r_valid;
  assign class_o    = r_class;
  assign max_o      = r_max;
  assign margin_o   = r_margin;
  assign no_spike_o = r_no_spike;

endmodule

// File: tb/tb_spike_readout_classifier.sv
// Randomised scoreboard bench for spike_readout_classifier: the driver pushes the
// expected result of each window, an independent monitor pops it on every valid_o.
module tb_spike_readout_classifier;
  localparam int NUM_CH  = 10;
  localparam int CNT_W   = 8;
  localparam int WIN_W   = 16;
  localparam int IDX_W   = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic              clk_i = 1'b0;
  logic              rst_ni = 1'b0;
  logic              start_i = 1'b0;
  logic              clear_i = 1'b0;
  logic              mode_i = 1'b0;
  logic [WIN_W-1:0]  window_len_i = '0;
  logic [NUM_CH-1:0] spike_i = '0;
  logic              busy_o;
  logic              valid_o;
  logic [IDX_W-1:0]  class_o;
  logic [CNT_W-1:0]  max_o;
  logic [CNT_W-1:0]  margin_o;
  logic              no_spike_o;

  typedef struct {
    int cls;
    int mx;
    int mg;
    int ns;
    int at;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   mcnt[NUM_CH];
  int   cyc   = 0;
  int   n_cmp = 0;
  int   n_fail = 0;
  int   n_res = 0;

  spike_readout_classifier #(
    .NUM_CH(NUM_CH), .CNT_W(CNT_W), .WIN_W(WIN_W), .IDX_W(IDX_W)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i), .clear_i(clear_i),
    .mode_i(mode_i), .window_len_i(window_len_i), .spike_i(spike_i),
    .busy_o(busy_o), .valid_o(valid_o), .class_o(class_o), .max_o(max_o),
    .margin_o(margin_o), .no_spike_o(no_spike_o)
  );

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [NUM_CH-1:0] gen(input int pat, input int s);
    logic [NUM_CH-1:0] v;
    v = '0;
    case (pat)
      0: v = NUM_CH'($urandom & $urandom);
      1: begin v[3] = (s <= 6); v[7] = (s <= 4); end
      2: begin v[2] = (s <= 5); v[5] = (s <= 5); end
      4: begin v = NUM_CH'($urandom & $urandom & $urandom); v[9] = 1'b1; end
      5: v[1] = (s == 1);
      default: v = '0;
    endcase
    return v;
  endfunction

  // Reference: sort the window's counts; winner is the lowest index holding the maximum.
  function automatic exp_t model(input int at);
    int   q[$];
    exp_t e;
    for (int k = 0; k < NUM_CH; k++) q.push_back(mcnt[k]);
    q.rsort();
    e.mx  = q[0];
    e.mg  = (NUM_CH > 1) ? q[0] - q[1] : q[0];
    e.cls = 0;
    for (int k = NUM_CH - 1; k >= 0; k--) if (mcnt[k] == e.mx) e.cls = k;
    e.ns  = (e.mx == 0) ? 1 : 0;
    e.at  = at;
    return e;
  endfunction

  task automatic run_window(input bit mode, input int len_raw, input int pat,
                            input int nwin, input bit poke_start);
    int   w;
    int   c0;
    exp_t e;
    w = (len_raw == 0) ? 1 : len_raw;
    start_i      = 1'b1;
    mode_i       = mode;
    window_len_i = WIN_W'(len_raw);
    spike_i      = gen(0, 0);
    @(posedge clk_i); #1;
    c0      = cyc;
    start_i = 1'b0;
    mode_i  = 1'($urandom);
    for (int n = 0; n < nwin; n++) begin
      for (int k = 0; k < NUM_CH; k++) mcnt[k] = 0;
      for (int s = 1; s <= w; s++) begin
        spike_i = gen(pat, s);
        start_i = poke_start && (s == 2);
        if (poke_start && s == 2) begin
          mode_i       = 1'b1;
          window_len_i = WIN_W'(3);
        end
        if (mode) window_len_i = WIN_W'($urandom_range(1, 50));
        for (int k = 0; k < NUM_CH; k++)
          if (spike_i[k] && mcnt[k] < CNT_MAX) mcnt[k]++;
        @(posedge clk_i); #1;
        start_i = 1'b0;
        if (n == 0 && s == 1) check("busy_in_accum", int'(busy_o), 1);
      end
      e = model(c0 + (n + 1) * (w + NUM_CH + 1));
      sb.push_back(e);
      for (int s = 0; s < NUM_CH + 1; s++) begin
        spike_i = gen(0, 0);
        @(posedge clk_i); #1;
      end
    end
    spike_i = '0;
  endtask

  always @(negedge clk_i) begin
    if (rst_ni && valid_o) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_valid: got valid_o=1 at cycle %0d, expected no result", cyc);
      end else begin
        mon_e = sb.pop_front();
        check("class_o",     int'(class_o),    mon_e.cls);
        check("max_o",       int'(max_o),      mon_e.mx);
        check("margin_o",    int'(margin_o),   mon_e.mg);
        check("no_spike_o",  int'(no_spike_o), mon_e.ns);
        check("valid_cycle", cyc,              mon_e.at);
        n_res++;
        $display("result %0d: cycle %0d class=%0d max=%0d margin=%0d no_spike=%0d",
                 n_res, cyc, class_o, max_o, margin_o, no_spike_o);
      end
    end
  end

  initial begin
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    check("rst_busy",     int'(busy_o),     0);
    check("rst_valid",    int'(valid_o),    0);
    check("rst_class",    int'(class_o),    0);
    check("rst_max",      int'(max_o),      0);
    check("rst_margin",   int'(margin_o),   0);
    check("rst_no_spike", int'(no_spike_o), 0);
    rst_ni = 1'b1;
    @(posedge clk_i); #1;

    // Basic one-shot: ch3 x6, ch7 x4
    run_window(0, 8, 1, 1, 0);
    @(negedge clk_i);
    check("busy_after_oneshot", int'(busy_o), 0);

    // Abort mid-scan with start in the same cycle; previous result must survive
    @(posedge clk_i); #1;
    start_i = 1'b1; mode_i = 1'b0; window_len_i = WIN_W'(4);
    @(posedge clk_i); #1;
    start_i = 1'b0;
    for (int s = 0; s < 4 + 3; s++) begin
      spike_i = gen(0, 0);
      @(posedge clk_i); #1;
    end
    clear_i = 1'b1; start_i = 1'b1;
    @(posedge clk_i); #1;
    clear_i = 1'b0; start_i = 1'b0; spike_i = '0;
    check("busy_after_clear",  int'(busy_o),   0);
    check("class_after_clear", int'(class_o),  3);
    check("max_after_clear",   int'(max_o),    6);
    check("margin_after_clear", int'(margin_o), 2);
    repeat (20) @(posedge clk_i);
    #1;
    check("busy_idle_after_clear", int'(busy_o), 0);

    // Tie, then empty window
    run_window(0, 8, 2, 1, 0);
    run_window(0, 8, 3, 1, 0);
    // Saturation, then zero length treated as one
    run_window(0, 300, 4, 1, 0);
    run_window(0, 0, 5, 1, 0);
    // start_i during ACCUM must be ignored
    run_window(0, 6, 0, 1, 1);
    @(negedge clk_i);
    check("busy_after_poke", int'(busy_o), 0);

    // Continuous: three back-to-back windows, then abort
    @(posedge clk_i); #1;
    run_window(1, 4, 0, 3, 0);
    clear_i = 1'b1;
    @(posedge clk_i); #1;
    clear_i = 1'b0;
    check("busy_after_cont_clear", int'(busy_o), 0);

    repeat (8) run_window(0, $urandom_range(0, 20), 0, 1, 0);
    run_window(1, $urandom_range(1, 12), 0, 2, 0);
    clear_i = 1'b1;
    @(posedge clk_i); #1;
    clear_i = 1'b0;

    // Asynchronous reset in the middle of a window
    run_window(0, 8, 1, 1, 0);
    @(posedge clk_i); #1;
    start_i = 1'b1; mode_i = 1'b1; window_len_i = WIN_W'(10);
    @(posedge clk_i); #1;
    start_i = 1'b0;
    repeat (3) begin
      spike_i = gen(0, 0);
      @(posedge clk_i); #1;
    end
    #2 rst_ni = 1'b0;
    #1;
    check("arst_busy",     int'(busy_o),     0);
    check("arst_valid",    int'(valid_o),    0);
    check("arst_class",    int'(class_o),    0);
    check("arst_max",      int'(max_o),      0);
    check("arst_margin",   int'(margin_o),   0);
    check("arst_no_spike", int'(no_spike_o), 0);
    spike_i = '0;
    repeat (2) @(posedge clk_i);
    #3 rst_ni = 1'b1;
    repeat (20) @(posedge clk_i);
    #1;
    check("busy_idle_after_reset", int'(busy_o), 0);
    check("pending_results", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
